frame_buf_pingpong: RTL and testbench

Parametrised double-buffered (ping-pong) frame memory, successor to the single-bank simple dual-port data memory. Two banks of 2^ADDR_WIDTH words each: the writer fills one bank while the reader drains the other, and a swap request exchanges the roles on a clock edge. Adds byte-enable writes, a read-valid flag, a frame counter and an automatic clear sweep after reset. Sits between the pixel producer and the display scan-out in the frame buffer path.

---
 rtl/frame_buf_pingpong.sv | 104 ++++++++++
 tb/tb_frame_buf_pingpong.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_pingpong.sv
// Double-buffered frame memory: writer fills one bank, reader drains the other.
// Byte-enable writes, read-valid flag, frame counter, clear sweep after reset.
module frame_buf_pingpong #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    wr_bank,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  running;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  sw_fire;

  logic [DATA_WIDTH-1:0] bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] bank1 [DEPTH];

  assign running = (state_q == RUN);
  assign rd_fire = running & rd_en;
  assign wr_fire = running & wr_en;
  assign sw_fire = running & swap_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (&clr_addr) state_d = RUN;
      RUN:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_addr  <= '0;
      wr_bank   <= 1'b0;
      frame_cnt <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      swap_ack  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d == CLEAR);
      rd_valid <= rd_fire;
      swap_ack <= sw_fire;
      if (state_q == CLEAR)
        clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (sw_fire) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end
      // read bank is the one not being written
      if (rd_fire)
        rd_data <= wr_bank ? bank0[rd_addr] : bank1[rd_addr];
    end
  end

  // Memory is deliberately outside the reset branch: reset never touches it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        bank0[clr_addr] <= CLEAR_VAL;
        bank1[clr_addr] <= CLEAR_VAL;
      end else if (wr_fire) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_be[i]) begin
            if (wr_bank)
              bank1[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            else
              bank0[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_pingpong.sv
// Directed bench for frame_buf_pingpong: clear sweep, ping-pong swaps,
// byte enables, same-cycle swap, resets, and long swap hold with wrap.
module tb_frame_buf_pingpong;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        swap_req;
  logic        swap_ack;
  logic        wr_bank;
  logic        busy;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  frame_buf_pingpong #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .CLEAR_VAL (16'hA5A5),
    .CNT_WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .wr_bank  (wr_bank),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp,
                    input string tag);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, exp);
    chk({tag, "_vld"}, rd_valid, 1);
  endtask

  task automatic swap(input logic exp_bank, input logic [7:0] exp_cnt);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_ack", swap_ack, 1);
    chk("swap_bank", wr_bank, exp_bank);
    chk("swap_cnt", frame_cnt, exp_cnt);
    tick();
    chk("swap_ack_drop", swap_ack, 0);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({tag, "_busy"}, busy, (i < 7) ? 1 : 0);
      chk({tag, "_ack"}, swap_ack, 0);
      chk({tag, "_vld"}, rd_valid, 0);
      chk({tag, "_bank"}, wr_bank, 0);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0; swap_req = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_bank", wr_bank, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_vld", rd_valid, 0);
    chk("rst_ack", swap_ack, 0);

    // accesses during the sweep must be ignored
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1'b1; swap_req = 1'b1;
    sweep("clr1");
    wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0;
    chk("clr1_cnt", frame_cnt, 0);

    for (int a = 0; a < 8; a++) rd(3'(a), 16'hA5A5, "clr_rd");
    tick();
    chk("idle_vld", rd_valid, 0);
    chk("idle_hold", rd_data, 16'hA5A5);

    // bank 0 writes, swap, read back
    for (int a = 1; a <= 4; a++) wr(3'(a), 16'(a), 2'b11);
    swap(1'b1, 8'd1);
    for (int a = 1; a <= 4; a++) rd(3'(a), 16'(a), "t2_rd");
    rd(3'd0, 16'hA5A5, "t2_rd0");
    rd(3'd5, 16'hA5A5, "t2_rd5");

    // byte enables
    wr(3'd2, 16'h1234, 2'b11);
    swap(1'b0, 8'd2);
    rd(3'd2, 16'h1234, "t3_base");
    swap(1'b1, 8'd3);
    wr(3'd2, 16'hABCD, 2'b01);
    swap(1'b0, 8'd4);
    rd(3'd2, 16'h12CD, "t3_be01");
    wr(3'd3, 16'hABCD, 2'b10);
    wr(3'd4, 16'hFFFF, 2'b00);
    swap(1'b1, 8'd5);
    rd(3'd3, 16'hAB03, "t3_be10");
    rd(3'd4, 16'h0004, "t3_be00");

    // same-cycle write, read and swap use the old banks
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0055; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 3'd5; swap_req = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0;
    chk("t4_old", rd_data, 16'hA5A5);
    chk("t4_vld", rd_valid, 1);
    chk("t4_ack", swap_ack, 1);
    chk("t4_bank", wr_bank, 0);
    chk("t4_cnt", frame_cnt, 6);
    rd(3'd5, 16'h0055, "t4_new");

    // reset in RUN with frame_cnt=7
    swap(1'b1, 8'd7);
    rd_en = 1'b1; swap_req = 1'b1; reset = 1'b1;
    tick();
    rd_en = 1'b0; swap_req = 1'b0;
    chk("t5_cnt", frame_cnt, 0);
    chk("t5_bank", wr_bank, 0);
    chk("t5_vld", rd_valid, 0);
    chk("t5_rdata", rd_data, 0);
    chk("t5_busy", busy, 1);
    chk("t5_ack", swap_ack, 0);

    // reset again three cycles into the sweep; sweep restarts in full
    reset = 1'b0;
    tick(); tick(); tick();
    chk("t5_mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep("clr2");
    rd(3'd2, 16'hA5A5, "t5_rd2");
    rd(3'd5, 16'hA5A5, "t5_rd5");

    // held swap: toggle every cycle, counter wraps
    swap_req = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      chk("t6_bank", wr_bank, 32'(i % 2));
      chk("t6_cnt", frame_cnt, 32'(i % 256));
      chk("t6_ack", swap_ack, 1);
    end
    swap_req = 1'b0;
    tick();
    chk("t6_ack_drop", swap_ack, 0);
    chk("t6_cnt_end", frame_cnt, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
